// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register bank with 2^ADDR_W x DATA_W entries, two combinational read ports,
// a pipeline writeback port and an MDU writeback port. Same-cycle writes are
// forwarded to the read ports. A per-register busy scoreboard tracks
// destinations of in-flight MDU operations so decode can stall on them. A
// sticky error flag records scoreboard protocol violations.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    register address width (depth = 2^ADDR_W)
//   ZERO_REG  1: register 0 reads as 0, drops writes, is never marked busy
//
// Ports
//   i_clk, i_rst                      clock (rising edge), async active-high reset
//   i_rd_addr1/2                      read addresses
//   o_rd_data1/2                      forwarded read data (combinational)
//   o_rd_busy1/2                      operand still pending from the MDU
//   i_wr_en/i_wr_addr/i_wr_data       pipeline writeback
//   i_mdu_issue/i_mdu_dest            MDU operation issue and its destination
//   i_mdu_wr_en/_addr/_data           MDU writeback
//   o_busy_any                        OR of all stored busy bits
//   o_err                             sticky protocol error
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_mdu_issue,
    input  logic [ADDR_W-1:0] i_mdu_dest,
    input  logic              i_mdu_wr_en,
    input  logic [ADDR_W-1:0] i_mdu_wr_addr,
    input  logic [DATA_W-1:0] i_mdu_wr_data,
    output logic              o_busy_any,
    output logic              o_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DEPTH-1:0] ONE_HOT_0 = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_err;

    // Write qualifiers: register 0 is read-only when ZERO_REG is set.
    logic w_wr_ok;
    logic w_mdu_wr_ok;
    logic w_issue_ok;

    assign w_wr_ok     = i_wr_en     && !(ZERO_REG && (i_wr_addr     == '0));
    assign w_mdu_wr_ok = i_mdu_wr_en && !(ZERO_REG && (i_mdu_wr_addr == '0));
    assign w_issue_ok  = i_mdu_issue && !(ZERO_REG && (i_mdu_dest    == '0));

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    // NOTE: the array is reset because reads after reset must return 0; this
    // keeps it in flops rather than a RAM macro, which is fine at this depth.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_regs[i_wr_addr] <= i_wr_data;
            end
            // NOTE: with non-blocking assignments the last one scheduled wins,
            // so placing the MDU write second gives it priority on a collision.
            if (w_mdu_wr_ok) begin
                r_regs[i_mdu_wr_addr] <= i_mdu_wr_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Busy scoreboard and error flag
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] w_set_vec;
    logic [DEPTH-1:0] w_clr_vec;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_err_issue;
    logic             w_err_wb;

    assign w_set_vec   = w_issue_ok  ? (ONE_HOT_0 << i_mdu_dest)    : '0;
    assign w_clr_vec   = i_mdu_wr_en ? (ONE_HOT_0 << i_mdu_wr_addr) : '0;
    // Set is applied after clear so a new issue supersedes a same-cycle writeback.
    assign w_busy_next = (r_busy & ~w_clr_vec) | w_set_vec;

    // Re-issue to a register that is still pending, unless its result lands now.
    assign w_err_issue = i_mdu_issue && r_busy[i_mdu_dest]
                         && !(i_mdu_wr_en && (i_mdu_wr_addr == i_mdu_dest));
    // Writeback with no outstanding operation for that register.
    assign w_err_wb    = i_mdu_wr_en && !r_busy[i_mdu_wr_addr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_err_issue || w_err_wb) begin
                r_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports with forwarding
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];

    assign w_rd_addr[0] = i_rd_addr1;
    assign w_rd_addr[1] = i_rd_addr2;

    // NOTE: every branch target gets a default at the top of the block so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            if (ZERO_REG && (w_rd_addr[p] == '0)) begin
                w_rd_data[p] = '0;
            end else if (i_mdu_wr_en && (i_mdu_wr_addr == w_rd_addr[p])) begin
                w_rd_data[p] = i_mdu_wr_data;
            end else if (i_wr_en && (i_wr_addr == w_rd_addr[p])) begin
                w_rd_data[p] = i_wr_data;
            end
            // The result arriving this cycle satisfies the operand immediately.
            w_rd_busy[p] = r_busy[w_rd_addr[p]]
                           && !(i_mdu_wr_en && (i_mdu_wr_addr == w_rd_addr[p]));
        end
    end

    assign o_rd_data1 = w_rd_data[0];
    assign o_rd_data2 = w_rd_data[1];
    assign o_rd_busy1 = w_rd_busy[0];
    assign o_rd_busy2 = w_rd_busy[1];
    assign o_busy_any = |r_busy;
    assign o_err      = r_err;

endmodule
